// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS PC sequencer slice.
// Holds the FSM state encodings, the PC increment, the default
// instruction-address width and the opcodes of the control-flow
// instructions the sequencer reacts to.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam int unsigned PC_INC     = 4;
    localparam int unsigned ADDR_W_DEF = 8;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

endpackage

// File: rtl/mips_pc_sequencer_if.sv
// Bus between the core/control side and the PC sequencer.
//   start, halt_req, stall    : sequencing controls
//   Branch, Zero, Jump        : decoded control flow from the core
//   SEImm, JumpValue          : branch offset / jump target, in words
//   ReadAddr                  : current PC to instruction memory
//   fetch_valid               : ReadAddr holds a live fetch
//   instr_count, state        : retire counter and FSM state code
// master = core/control side, slave = sequencer.
interface mips_pc_sequencer_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              halt_req;
    logic              stall;
    logic              Branch;
    logic              Zero;
    logic              Jump;
    logic [31:0]       SEImm;
    logic [25:0]       JumpValue;
    logic [ADDR_W-1:0] ReadAddr;
    logic              fetch_valid;
    logic [15:0]       instr_count;
    logic [1:0]        state;

    modport master (
        output start, halt_req, stall, Branch, Zero, Jump, SEImm, JumpValue,
        input  ReadAddr, fetch_valid, instr_count, state
    );

    modport slave (
        input  start, halt_req, stall, Branch, Zero, Jump, SEImm, JumpValue,
        output ReadAddr, fetch_valid, instr_count, state
    );
endinterface

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection.
//   pc        : current PC
//   Branch    : beq decoded, Zero : ALU zero flag
//   Jump      : j decoded
//   SEImm     : sign-extended branch offset in words
//   JumpValue : j-type target field in words
//   next_pc   : selected next PC (Jump > taken branch > sequential)
// All arithmetic is modulo 2^ADDR_W.
module mips_next_pc
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              Jump,
    input  logic [31:0]       SEImm,
    input  logic [25:0]       JumpValue,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] pc_plus4;

    always_comb begin
        pc_plus4 = pc + ADDR_W'(PC_INC);
        if (Jump) begin
            next_pc = ADDR_W'({JumpValue, 2'b00});
        end else if (Branch && Zero) begin
            // Word offset becomes a byte offset; truncation gives the wrap.
            next_pc = pc_plus4 + ADDR_W'(SEImm << 2);
        end else begin
            next_pc = pc_plus4;
        end
    end
endmodule

// File: rtl/mips_pc_sequencer.sv
// PC sequencer: IDLE/RUN/HALT FSM, PC register and retire counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mips_pc_sequencer_if (controls in,
//                ReadAddr / fetch_valid / instr_count / state out)
// An instruction retires on every RUN cycle without stall; only then
// do the PC and counter advance. The halting instruction also retires.
module mips_pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_pc_sequencer_if.slave   bus
);
    state_t            cur_state;
    state_t            nxt_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [15:0]       count;
    logic              retire;

    assign retire = (cur_state == RUN) && !bus.stall;

    mips_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc        (pc),
        .Branch    (bus.Branch),
        .Zero      (bus.Zero),
        .Jump      (bus.Jump),
        .SEImm     (bus.SEImm),
        .JumpValue (bus.JumpValue),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        unique case (cur_state)
            IDLE:    if (bus.start) nxt_state = RUN;
            // A stalled instruction must finish before halting.
            RUN:     if (bus.halt_req && !bus.stall) nxt_state = HALT;
            HALT:    if (bus.start) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        bus.fetch_valid = (cur_state == RUN);
        bus.state       = cur_state;
        bus.ReadAddr    = pc;
        bus.instr_count = count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            count <= '0;
        end else if (retire) begin
            pc    <= next_pc;
            count <= count + 16'd1;
        end
    end
endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Self-checking bench for mips_pc_sequencer: directed sequences with
// literal expectations, then randomized traffic compared every cycle
// against an arithmetic reference model.
module tb_mips_pc_sequencer;

    localparam int MASK = 255;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic check_en;

    mips_pc_sequencer_if #(.ADDR_W(8)) bus ();

    mips_pc_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=halt
    int m_pc, m_cnt, m_st, m_ns;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc  = 0;
            m_cnt = 0;
            m_st  = 0;
        end else begin
            m_ns = m_st;
            if (m_st == 0 && bus.start) m_ns = 1;
            else if (m_st == 1 && bus.halt_req && !bus.stall) m_ns = 2;
            else if (m_st == 2 && bus.start) m_ns = 0;
            if (m_st == 1 && !bus.stall) begin
                if (bus.Jump)
                    m_pc = (int'(bus.JumpValue) * 4) & MASK;
                else if (bus.Branch && bus.Zero)
                    m_pc = (m_pc + 4 + int'($signed(bus.SEImm)) * 4) & MASK;
                else
                    m_pc = (m_pc + 4) & MASK;
                m_cnt = (m_cnt + 1) % 65536;
            end
            m_st = m_ns;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pc",    32'(bus.ReadAddr),    32'(m_pc));
            chk("model_count", 32'(bus.instr_count), 32'(m_cnt));
            chk("model_state", 32'(bus.state),       32'(m_st));
            chk("model_fv",    32'(bus.fetch_valid), 32'(m_st == 1));
        end
    end

    task automatic drive(input logic s, input logic h, input logic st,
                         input logic br, input logic z, input logic j,
                         input logic [31:0] se, input logic [25:0] jv);
        bus.start     = s;
        bus.halt_req  = h;
        bus.stall     = st;
        bus.Branch    = br;
        bus.Zero      = z;
        bus.Jump      = j;
        bus.SEImm     = se;
        bus.JumpValue = jv;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
    endtask

    task automatic jump_to(input logic [25:0] jv);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, jv);
    endtask

    logic [15:0] saved_cnt;

    initial begin
        tests    = 0;
        fails    = 0;
        check_en = 1'b0;
        rst_n    = 1'b0;
        bus.start = 1'b0; bus.halt_req = 1'b0; bus.stall = 1'b0;
        bus.Branch = 1'b0; bus.Zero = 1'b0; bus.Jump = 1'b0;
        bus.SEImm = '0; bus.JumpValue = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_en = 1'b1;

        chk("reset_pc",    32'(bus.ReadAddr),    32'h00);
        chk("reset_state", 32'(bus.state),       32'h0);
        chk("reset_fv",    32'(bus.fetch_valid), 32'h0);
        chk("reset_count", 32'(bus.instr_count), 32'h0);

        idle_step();
        chk("idle_hold", 32'(bus.state), 32'h0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        chk("start_run", 32'(bus.state), 32'h1);
        chk("start_fv",  32'(bus.fetch_valid), 32'h1);

        for (int i = 0; i < 7; i++) begin
            chk("seq_pc", 32'(bus.ReadAddr), 32'(i * 4));
            idle_step();
        end
        chk("seq_count", 32'(bus.instr_count), 32'd7);
        chk("seq_pc_end", 32'(bus.ReadAddr), 32'h1C);

        jump_to(26'd4);
        chk("jump_0x10", 32'(bus.ReadAddr), 32'h10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 26'd0);
        chk("beq_taken", 32'(bus.ReadAddr), 32'h10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 26'd0);
        chk("beq_not_taken", 32'(bus.ReadAddr), 32'h14);
        idle_step();
        chk("pc_0x18", 32'(bus.ReadAddr), 32'h18);
        jump_to(26'h0100004);
        chk("jump_trunc", 32'(bus.ReadAddr), 32'h10);
        jump_to(26'd6);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 26'd4);
        chk("jump_over_branch", 32'(bus.ReadAddr), 32'h10);

        jump_to(26'h3F);
        chk("pc_0xFC", 32'(bus.ReadAddr), 32'hFC);
        idle_step();
        chk("wrap", 32'(bus.ReadAddr), 32'h00);

        idle_step();
        idle_step();
        saved_cnt = bus.instr_count;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
            chk("stall_pc",    32'(bus.ReadAddr),    32'h08);
            chk("stall_count", 32'(bus.instr_count), 32'(saved_cnt));
        end

        idle_step();
        saved_cnt = bus.instr_count;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        chk("halt_stalled_state", 32'(bus.state),    32'h1);
        chk("halt_stalled_pc",    32'(bus.ReadAddr), 32'h0C);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        chk("halt_state", 32'(bus.state),       32'h2);
        chk("halt_pc",    32'(bus.ReadAddr),    32'h10);
        chk("halt_fv",    32'(bus.fetch_valid), 32'h0);
        chk("halt_count", 32'(bus.instr_count), 32'(saved_cnt + 16'd1));

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        chk("halt_to_idle", 32'(bus.state), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        chk("idle_to_run", 32'(bus.state), 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
        chk("start_in_run", 32'(bus.state),    32'h1);
        chk("start_in_run_pc", 32'(bus.ReadAddr), 32'h14);

        // Asynchronous reset between edges while stalled at 0x14.
        bus.stall = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc",    32'(bus.ReadAddr),    32'h00);
        chk("async_rst_state", 32'(bus.state),       32'h0);
        chk("async_rst_count", 32'(bus.instr_count), 32'h0);
        chk("async_rst_fv",    32'(bus.fetch_valid), 32'h0);
        #1;
        rst_n = 1'b1;
        idle_step();
        idle_step();
        chk("post_rst_idle", 32'(bus.state), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] se;
            if ($urandom_range(0, 3) == 0)
                se = $urandom;
            else
                se = 32'($signed($urandom_range(0, 31)) - 16);
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 5) == 0,
                  se,
                  26'($urandom));
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
